// File: rtl/spi_frame_rx.sv
// SPI-slave (mode 0) frame receiver: header, three payload words and an XOR checksum.
// A good frame updates buffer_2/buffer_3/reff together; bad or aborted frames are counted.
module spi_frame_rx #(
   parameter int                   DW          = 14,
   parameter int                   WORD_BITS   = 16,
   parameter logic [WORD_BITS-1:0] HEADER      = 16'hA5A5,
   parameter int                   SYNC_STAGES = 2,
   parameter int                   TIMEOUT     = 4095
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sck,
   input  logic          cs,
   input  logic          mosi,
   output logic [DW-1:0] buffer_2,
   output logic [DW-1:0] buffer_3,
   output logic [DW-1:0] reff,
   output logic          head_flag,
   output logic          frame_err,
   output logic [7:0]    err_cnt
);

   localparam int                BC_W     = $clog2(WORD_BITS);
   localparam int                TO_W     = $clog2(TIMEOUT + 1);
   localparam logic [BC_W-1:0]   BIT_LAST = BC_W'(WORD_BITS - 1);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, HDR, PAY, CHK, WAIT_CS} state_t;

   state_t                 state_r;
   logic [SYNC_STAGES-1:0] sck_sync_r, cs_sync_r, mosi_sync_r;
   logic                   sck_prev_r, cs_prev_r;
   logic [WORD_BITS-2:0]   sreg_r;
   logic [BC_W-1:0]        bit_cnt_r;
   logic [1:0]             word_cnt_r;
   logic [TO_W-1:0]        to_cnt_r;
   logic [WORD_BITS-1:0]   pay0_r, pay1_r, pay2_r;
   logic                   bad_r;

   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise_s, cs_fall_s, cs_rise_s;
   logic [WORD_BITS-1:0]   word_s, xor_s;
   logic                   word_done_s, hi_bad_s;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign sck_s       = sck_sync_r[SYNC_STAGES-1];
   assign cs_s        = cs_sync_r[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
   assign sck_rise_s  = sck_s & ~sck_prev_r;
   assign cs_fall_s   = ~cs_s & cs_prev_r;
   assign cs_rise_s   = cs_s & ~cs_prev_r;
   assign word_s      = {sreg_r, mosi_s};
   assign word_done_s = sck_rise_s && (bit_cnt_r == BIT_LAST);
   assign hi_bad_s    = |word_s[WORD_BITS-1:DW];
   assign xor_s       = pay0_r ^ pay1_r ^ pay2_r;

   // Pin synchronizers; cs resets low so a frame already in progress is not picked up mid-way.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_sync_r  <= '0;
         cs_sync_r   <= '0;
         mosi_sync_r <= '0;
         sck_prev_r  <= 1'b0;
         cs_prev_r   <= 1'b0;
      end else begin
         sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
         cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
         sck_prev_r  <= sck_s;
         cs_prev_r   <= cs_s;
      end
   end

   // Frame FSM with shift register, counters, staging and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         sreg_r     <= '0;
         bit_cnt_r  <= '0;
         word_cnt_r <= 2'd0;
         to_cnt_r   <= '0;
         pay0_r     <= '0;
         pay1_r     <= '0;
         pay2_r     <= '0;
         bad_r      <= 1'b0;
         buffer_2   <= '0;
         buffer_3   <= '0;
         reff       <= '0;
         head_flag  <= 1'b0;
         frame_err  <= 1'b0;
         err_cnt    <= 8'd0;
      end else begin
         head_flag <= 1'b0;
         frame_err <= 1'b0;
         case (state_r)
            IDLE: begin
               if (cs_fall_s) begin
                  state_r    <= HDR;
                  bit_cnt_r  <= '0;
                  word_cnt_r <= 2'd0;
                  to_cnt_r   <= '0;
                  bad_r      <= 1'b0;
               end else begin
                  state_r <= IDLE;
               end
            end
            HDR, PAY, CHK: begin
               if (cs_rise_s) begin
                  if (state_r != HDR) begin
                     frame_err <= 1'b1;
                     err_cnt   <= sat_inc(err_cnt);
                  end else begin
                     frame_err <= 1'b0;
                  end
                  state_r <= IDLE;
               end else if (sck_rise_s) begin
                  sreg_r    <= word_s[WORD_BITS-2:0];
                  to_cnt_r  <= '0;
                  bit_cnt_r <= word_done_s ? '0 : bit_cnt_r + 1'b1;
                  if (word_done_s) begin
                     case (state_r)
                        HDR: state_r <= (word_s == HEADER) ? PAY : WAIT_CS;
                        PAY: begin
                           case (word_cnt_r)
                              2'd0:    pay0_r <= word_s;
                              2'd1:    pay1_r <= word_s;
                              default: pay2_r <= word_s;
                           endcase
                           if (hi_bad_s) bad_r <= 1'b1;
                           word_cnt_r <= word_cnt_r + 2'd1;
                           state_r    <= (word_cnt_r == 2'd2) ? CHK : PAY;
                        end
                        CHK: begin
                           if (word_s == xor_s && !bad_r) begin
                              buffer_2  <= pay0_r[DW-1:0];
                              buffer_3  <= pay1_r[DW-1:0];
                              reff      <= pay2_r[DW-1:0];
                              head_flag <= 1'b1;
                           end else begin
                              frame_err <= 1'b1;
                              err_cnt   <= sat_inc(err_cnt);
                           end
                           state_r <= WAIT_CS;
                        end
                        default: state_r <= IDLE;
                     endcase
                  end
               end else if (to_cnt_r == TO_LAST) begin
                  frame_err <= 1'b1;
                  err_cnt   <= sat_inc(err_cnt);
                  state_r   <= WAIT_CS;
               end else begin
                  to_cnt_r <= to_cnt_r + 1'b1;
               end
            end
            WAIT_CS: state_r <= cs_rise_s ? IDLE : WAIT_CS;
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomized bench for spi_frame_rx: a frame-level model pushes expected events, a monitor
// pops and checks them whenever head_flag or frame_err fires.
module tb_spi_frame_rx;

   localparam logic [15:0] HDR_W = 16'hA5A5;

   logic        clk = 1'b0;
   logic        rst, sck, cs, mosi;
   logic [13:0] buffer_2, buffer_3, reff;
   logic        head_flag, frame_err;
   logic [7:0]  err_cnt;

   typedef struct {
      bit          good;
      bit          tmo;
      logic [13:0] b2, b3, rf;
      int          cnt;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          exp_err = 0;
   int          cyc = 0;
   int          last_rise_cyc = 0;
   bit          mon_en = 1'b0;
   logic [13:0] cur_b2 = '0, cur_b3 = '0, cur_rf = '0;

   spi_frame_rx dut (
      .clk(clk), .rst(rst), .sck(sck), .cs(cs), .mosi(mosi),
      .buffer_2(buffer_2), .buffer_3(buffer_3), .reff(reff),
      .head_flag(head_flag), .frame_err(frame_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Frame-level reference: decides the single outcome (if any) of one transmitted frame.
   task automatic model(input logic [79:0] f, input int nbits, input bit stall);
      logic [15:0] w[5];
      exp_t e;
      for (int k = 0; k < 5; k++) w[k] = f[79-16*k -: 16];
      if (nbits < 16 || w[0] != HDR_W) return;
      e.tmo = stall;
      e.b2  = w[1][13:0];
      e.b3  = w[2][13:0];
      e.rf  = w[3][13:0];
      e.good = !stall && nbits >= 80 && w[1] <= 16'h3FFF && w[2] <= 16'h3FFF &&
               w[3] <= 16'h3FFF && w[4] == (w[1] ^ w[2] ^ w[3]);
      if (!e.good && exp_err < 255) exp_err++;
      e.cnt = exp_err;
      sb.push_back(e);
   endtask

   task automatic send_bit(input logic b);
      mosi = b;
      tick(4);
      sck = 1'b1;
      last_rise_cyc = cyc;
      tick(4);
      sck = 1'b0;
   endtask

   task automatic send_frame(input logic [79:0] f, input int nbits, input int stall_at);
      model(f, nbits, stall_at >= 0 && stall_at < nbits);
      cs = 1'b0;
      tick(4);
      for (int i = 0; i < nbits; i++) begin
         if (i == stall_at) tick(4150);
         send_bit(f[79-i]);
      end
      tick(4);
      cs = 1'b1;
      tick(12);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
      chk("pending_events", sb.size(), 0);
   endtask

   function automatic logic [79:0] mk(input logic [15:0] h, input logic [15:0] a,
                                      input logic [15:0] b, input logic [15:0] c,
                                      input logic [15:0] x);
      return {h, a, b, c, x};
   endfunction

   // Monitor: pops an expected event on each output pulse, otherwise checks the buffers hold.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && !rst) begin
         if (head_flag && frame_err) begin
            chk("flags_exclusive", 1, 0);
         end else if (head_flag || frame_err) begin
            if (sb.size() == 0) begin
               chk("unexpected_pulse", {head_flag, frame_err}, 0);
            end else begin
               e = sb.pop_front();
               chk("event_kind", head_flag, e.good);
               if (e.good) begin
                  cur_b2 = e.b2;
                  cur_b3 = e.b3;
                  cur_rf = e.rf;
               end
               chk("buffer_2", buffer_2, cur_b2);
               chk("buffer_3", buffer_3, cur_b3);
               chk("reff", reff, cur_rf);
               chk("err_cnt", err_cnt, e.cnt);
               if (e.tmo) begin
                  checks++;
                  if (cyc - last_rise_cyc < 4090 || cyc - last_rise_cyc > 4105) begin
                     errors++;
                     $display("FAIL timeout_latency: got %0d cycles expected about 4098",
                              cyc - last_rise_cyc);
                  end
               end
            end
         end else begin
            chk("hold_buffers", {buffer_2, buffer_3, reff}, {cur_b2, cur_b3, cur_rf});
         end
      end
   end

   initial begin
      logic [79:0] good_f;
      logic [15:0] p1, p2, p3, cs_w, h;
      int          mode, nb;
      rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
      tick(3);
      chk("rst_buffer_2", buffer_2, 0);
      chk("rst_buffer_3", buffer_3, 0);
      chk("rst_reff", reff, 0);
      chk("rst_flags", {head_flag, frame_err}, 0);
      chk("rst_err_cnt", err_cnt, 0);
      rst = 1'b0;
      tick(4);
      mon_en = 1'b1;

      good_f = mk(HDR_W, 16'h1234, 16'h0ABC, 16'h2000, 16'h3888);

      // Reset mid-frame with cs held low: rest of the frame must be ignored.
      cs = 1'b0;
      tick(4);
      for (int i = 0; i < 30; i++) send_bit(good_f[79-i]);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      for (int i = 30; i < 80; i++) send_bit(good_f[79-i]);
      tick(4);
      cs = 1'b1;
      tick(12);
      drain();

      send_frame(good_f, 80, -1);
      send_frame(mk(HDR_W, 16'h1234, 16'h0ABC, 16'h2000, 16'h3889), 80, -1);
      send_frame(mk(16'h5A5A, 16'h1234, 16'h0ABC, 16'h2000, 16'h3888), 80, -1);
      send_frame(mk(HDR_W, 16'h0111, 16'h0222, 16'h0333, 16'h0111 ^ 16'h0222 ^ 16'h0333), 80, -1);
      send_frame(good_f, 40, -1);
      send_frame(mk(HDR_W, 16'h3FFF, 16'h0001, 16'h2AAA, 16'h3FFF ^ 16'h0001 ^ 16'h2AAA), 80, -1);
      send_frame(good_f, 80, 40);
      send_frame(mk(HDR_W, 16'h1111, 16'h2222, 16'h0444, 16'h1111 ^ 16'h2222 ^ 16'h0444), 80, -1);
      send_frame(mk(HDR_W, 16'h4234, 16'h0ABC, 16'h2000, 16'h4234 ^ 16'h0ABC ^ 16'h2000), 80, -1);
      drain();

      for (int n = 0; n < 300; n++) send_frame(good_f, 17, -1);
      drain();
      chk("err_cnt_saturated", err_cnt, 255);

      for (int n = 0; n < 20; n++) begin
         p1   = 16'($urandom_range(0, 16'h3FFF));
         p2   = 16'($urandom_range(0, 16'h3FFF));
         p3   = 16'($urandom_range(0, 16'h3FFF));
         h    = HDR_W;
         nb   = 80;
         mode = $urandom_range(0, 5);
         if (mode == 2) p2 = p2 | 16'h4000;
         cs_w = p1 ^ p2 ^ p3;
         case (mode)
            0:       h = 16'($urandom);
            1:       nb = $urandom_range(1, 79);
            3:       cs_w = cs_w ^ (16'h0001 << $urandom_range(0, 15));
            default: h = HDR_W;
         endcase
         send_frame(mk(h, p1, p2, p3, cs_w), nb, -1);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
